puf_response_voter: RTL and testbench

- Downstream consumer of the 32-bit arbiter-PUF response array. It drives the PUF challenge bus and the PUF arbiter-clear pulse.
- It runs NUM_EVAL repeated evaluations of one challenge, then majority-votes each response bit to give a stable response.
- It also flags the bits whose samples disagreed.
- The result goes to the key/ID logic over a valid/ready handshake.

---
 rtl/puf_response_voter.sv | 107 ++++++++++
 tb/tb_puf_response_voter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/puf_response_voter.sv
// puf_response_voter: repeats one PUF challenge NUM_EVAL times, majority-votes each
// response bit and flags bits whose samples disagreed, delivered over valid/ready.
module puf_response_voter #(
    parameter int WIDTH         = 32,
    parameter int NUM_EVAL      = 7,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] chal_in,
    output logic [WIDTH-1:0] C,
    output logic             puf_clr,
    input  logic [WIDTH-1:0] O_in,
    output logic             busy,
    output logic [WIDTH-1:0] resp,
    output logic [WIDTH-1:0] unstable_mask,
    output logic             resp_valid,
    input  logic             resp_ready
);
    if (NUM_EVAL < 1 || NUM_EVAL > 15 || NUM_EVAL % 2 == 0) begin : g_bad_eval
        $error("NUM_EVAL must be odd and within 1..15");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be within 1..255");
    end

    localparam logic [3:0] NE   = 4'(NUM_EVAL);
    localparam logic [3:0] HALF = 4'((NUM_EVAL - 1) / 2);
    localparam logic [7:0] SC   = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CLRP, SETTLE, SAMPLE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d, resp_q, resp_d, mask_q, mask_d;
    logic [3:0]       cnt_q [WIDTH];
    logic [3:0]       cnt_d [WIDTH];
    logic [3:0]       eval_q, eval_d;
    logic [7:0]       settle_q, settle_d;

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        resp_d   = resp_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        eval_d   = eval_q;
        settle_d = settle_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = CLRP;
                c_d     = chal_in;
                eval_d  = '0;
                for (int i = 0; i < WIDTH; i++) cnt_d[i] = '0;
            end
            CLRP: begin
                state_d  = SETTLE;
                settle_d = SC;
            end
            SETTLE: begin
                state_d  = (settle_q == '0) ? SAMPLE : SETTLE;
                settle_d = (settle_q == '0) ? settle_q : settle_q - 8'd1;
            end
            SAMPLE: begin
                for (int i = 0; i < WIDTH; i++) cnt_d[i] = cnt_q[i] + {3'b0, O_in[i]};
                eval_d  = eval_q + 4'd1;
                state_d = (eval_d == NE) ? DONE : CLRP;
                // vote on the updated counts so the last sample is included
                if (eval_d == NE) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        resp_d[i] = cnt_d[i] > HALF;
                        mask_d[i] = (cnt_d[i] != '0) && (cnt_d[i] != NE);
                    end
                end
            end
            DONE:    state_d = resp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= IDLE;
            c_q      <= '0;
            resp_q   <= '0;
            mask_q   <= '0;
            eval_q   <= '0;
            settle_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            resp_q   <= resp_d;
            mask_q   <= mask_d;
            eval_q   <= eval_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
        end
    end

    assign C             = c_q;
    assign resp          = resp_q;
    assign unstable_mask = mask_q;
    assign puf_clr       = state_q == CLRP;
    assign busy          = state_q != IDLE;
    assign resp_valid    = state_q == DONE;
endmodule

// File: tb/tb_puf_response_voter.sv
// tb_puf_response_voter: table vectors, randomized runs against a bit-count model,
// and hand sequences for reset, backpressure, ignored starts and back-to-back.
`timescale 1ns/1ps
module tb_puf_response_voter;
    typedef logic [31:0] smp_t [7];
    typedef struct {
        logic [31:0] chal;
        smp_t        s;
        logic [31:0] er;
        logic [31:0] em;
    } vec_t;

    logic        clk, clr, start, puf_clr, busy, resp_valid, resp_ready;
    logic [31:0] chal_in, C, O_in, resp, unstable_mask;
    int          n_chk = 0;
    int          n_fail = 0;

    puf_response_voter dut (
        .clk(clk), .clr(clr), .start(start), .chal_in(chal_in), .C(C),
        .puf_clr(puf_clr), .O_in(O_in), .busy(busy), .resp(resp),
        .unstable_mask(unstable_mask), .resp_valid(resp_valid), .resp_ready(resp_ready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Vote computed by counting ones per bit across the samples
    task automatic model(input smp_t s, output logic [31:0] r, output logic [31:0] m);
        for (int b = 0; b < 32; b++) begin
            int c = 0;
            for (int k = 0; k < 7; k++) c += s[k][b] ? 1 : 0;
            r[b] = (2 * c > 7);
            m[b] = (c != 0) && (c != 7);
        end
    endtask

    // One full evaluation; sample k is presented during cycles 6k..6k+5 after accept
    task automatic run_eval(input logic [31:0] chal, input smp_t s, input int hold,
                            input bit poke, output logic [31:0] r, output logic [31:0] m);
        logic [63:0] pulses = '0;
        logic [63:0] exp_p = '0;
        int          rise = -1;
        bit          cbad = 0;
        bit          sbad = 0;
        for (int k = 0; k < 7; k++) exp_p[6*k] = 1'b1;
        start = 1; chal_in = chal; O_in = s[0];
        @(posedge clk); #1;
        start = 0; chal_in = $urandom;
        if (puf_clr) pulses[0] = 1'b1;
        if (C !== chal) cbad = 1;
        for (int e = 1; e <= 60 && rise < 0; e++) begin
            O_in = s[((e - 1) / 6 > 6) ? 6 : (e - 1) / 6];
            if (poke && e == 3) begin start = 1; chal_in = 32'h1234_5678; end
            @(posedge clk); #1;
            start = 0;
            if (puf_clr) pulses[e] = 1'b1;
            if (C !== chal) cbad = 1;
            if (resp_valid) rise = e;
        end
        chk("clr_pulses", pulses, exp_p);
        chk("valid_edge", 64'(rise), 64'd42);
        chk("chal_hold", 64'(cbad), 64'd0);
        chk("busy_done", 64'(busy), 64'd1);
        r = resp; m = unstable_mask;
        for (int h = 0; h < hold; h++) begin
            if (poke && h == 1) begin start = 1; chal_in = 32'h1234_5678; end
            @(posedge clk); #1;
            start = 0;
            if (resp !== r || unstable_mask !== m || !resp_valid || puf_clr || C !== chal) sbad = 1;
        end
        chk("bp_stable", 64'(sbad), 64'd0);
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        chk("hs_valid_busy", {62'd0, resp_valid, busy}, 64'd0);
        chk("hs_result_kept", {resp, unstable_mask}, {r, m});
        @(posedge clk); #1;
        chk("idle_after", {62'd0, busy, puf_clr}, 64'd0);
        chk("c_kept", 64'(C), 64'(chal));
    endtask

    vec_t        tbl [5];
    logic [31:0] r, m, er, em;
    smp_t        s;

    initial begin
        tbl[0].chal = 32'hA5A5_0F0F; tbl[0].er = 32'hFFFF_FFFF; tbl[0].em = 32'h0;
        tbl[1].chal = 32'h0000_0011; tbl[1].er = 32'h0000_0001; tbl[1].em = 32'h0000_0003;
        tbl[2].chal = 32'hDEAD_BEEF; tbl[2].er = 32'h0;         tbl[2].em = 32'h0;
        tbl[3].chal = 32'h0F0F_F0F0; tbl[3].er = 32'hAAAA_AAAA; tbl[3].em = 32'hFFFF_FFFF;
        tbl[4].chal = 32'h7777_1111; tbl[4].er = 32'h0;         tbl[4].em = 32'hF0F0_F0F0;
        for (int k = 0; k < 7; k++) begin
            tbl[0].s[k] = 32'hFFFF_FFFF;
            tbl[1].s[k] = (k < 4) ? 32'h1 : 32'h2;
            tbl[2].s[k] = 32'h0;
            tbl[3].s[k] = (k < 4) ? 32'hAAAA_AAAA : 32'h5555_5555;
            tbl[4].s[k] = (k < 3) ? 32'hF0F0_F0F0 : 32'h0;
        end

        start = 0; chal_in = 0; O_in = 0; resp_ready = 0;
        clr = 1;
        #2 clr = 0;
        #2;
        chk("reset_regs", {C, resp}, 64'd0);
        chk("reset_flags", {29'd0, unstable_mask, puf_clr, busy, resp_valid}, 64'd0);
        repeat (2) @(negedge clk);
        clr = 1;
        @(posedge clk); #1;
        chk("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 5; i++) begin
            run_eval(tbl[i].chal, tbl[i].s, (i == 2) ? 10 : i, i == 3, r, m);
            chk($sformatf("tbl%0d_resp", i), 64'(r), 64'(tbl[i].er));
            chk($sformatf("tbl%0d_mask", i), 64'(m), 64'(tbl[i].em));
        end

        for (int i = 0; i < 15; i++) begin
            logic [31:0] base, noise;
            base = $urandom;
            noise = $urandom & $urandom;
            for (int k = 0; k < 7; k++) s[k] = base ^ (noise & $urandom);
            model(s, er, em);
            run_eval($urandom, s, $urandom_range(0, 5), $urandom_range(0, 1) == 1, r, m);
            chk($sformatf("rnd%0d_resp", i), 64'(r), 64'(er));
            chk($sformatf("rnd%0d_mask", i), 64'(m), 64'(em));
        end

        // Asynchronous reset during the third SETTLE
        start = 1; chal_in = 32'hCAFE_F00D; O_in = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 0;
        repeat (14) @(posedge clk);
        #3 clr = 0;
        #1;
        chk("abort_regs", {C, resp}, 64'd0);
        chk("abort_flags", {29'd0, unstable_mask, puf_clr, busy, resp_valid}, 64'd0);
        @(negedge clk); clr = 1;
        repeat (3) @(posedge clk); #1;
        chk("abort_no_valid", {62'd0, resp_valid, busy}, 64'd0);
        run_eval(tbl[1].chal, tbl[1].s, 2, 0, r, m);
        chk("after_abort_resp", {r, m}, {tbl[1].er, tbl[1].em});

        // Back-to-back with start and resp_ready held high
        begin
            int r1 = -1;
            int r2 = -1;
            bit prev = 0;
            start = 1; resp_ready = 1; chal_in = $urandom; O_in = $urandom;
            for (int e = 0; e < 150 && r2 < 0; e++) begin
                @(posedge clk); #1;
                if (resp_valid && !prev) begin
                    if (r1 < 0) r1 = e; else r2 = e;
                end
                prev = resp_valid;
            end
            start = 0;
            chk("b2b_first", 64'(r1), 64'd42);
            chk("b2b_second", 64'(r2), 64'd86);
            @(posedge clk); #1;
            resp_ready = 0;
            chk("b2b_idle", 64'(busy), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
